// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol encodings, code-word geometry and the
// playback state type used by the encoder and the decoder/player side.
package morse_pkg;

    localparam int unsigned CODE_W   = 10;
    localparam int unsigned SYM_W    = 2;
    localparam int unsigned NUM_SYMS = CODE_W / SYM_W;

    localparam logic [SYM_W-1:0] MORSE_NONE = 2'b00;
    localparam logic [SYM_W-1:0] MORSE_DOT  = 2'b01;
    localparam logic [SYM_W-1:0] MORSE_LINE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_MARK,
        ST_GAP,
        ST_DONE
    } morse_state_t;

    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

    // 2'b10 is not a legal symbol and is played as silence.
    function automatic logic is_mark(input logic [SYM_W-1:0] sym);
        return (sym == MORSE_DOT) || (sym == MORSE_LINE);
    endfunction

endpackage

// File: rtl/morse_timer.sv
// Loadable down-counter that parks at zero; zero flag is combinational on
// the registered count.
module morse_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (!zero) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/morse_encoder.sv
// Plays a latched 5-symbol Morse code word out as a timed mark/gap waveform.
// Dots and lines are sounded; none/invalid symbols each cost one silent cycle.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 12500000,
    parameter int unsigned DOT_UNITS   = 1,
    parameter int unsigned LINE_UNITS  = 3,
    parameter int unsigned GAP_UNITS   = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    output logic              busy,
    output logic              done,
    output logic              morse_out,
    output logic [SYM_W-1:0]  cur_symbol
);

    localparam int unsigned DOT_CYC  = DOT_UNITS * UNIT_CYCLES;
    localparam int unsigned LINE_CYC = LINE_UNITS * UNIT_CYCLES;
    localparam int unsigned GAP_CYC  = GAP_UNITS * UNIT_CYCLES;
    localparam int unsigned MAX_CYC  = (LINE_CYC > DOT_CYC) ? LINE_CYC : DOT_CYC;
    localparam int unsigned CNT_W    = cnt_width(MAX_CYC);
    localparam int unsigned REM_W    = $clog2(NUM_SYMS + 1);

    // The gap load is two short: the FETCH cycle that follows supplies the
    // last low cycle of the inter-mark gap.
    localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(DOT_CYC - 1);
    localparam logic [CNT_W-1:0] LINE_LOAD = CNT_W'(LINE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 2);
    localparam logic [REM_W-1:0] REM_INIT  = REM_W'(NUM_SYMS);

    morse_state_t      state;
    logic [CODE_W-1:0] shreg;
    logic [REM_W-1:0]  rem;
    logic [SYM_W-1:0]  sym;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_value;
    logic              tmr_zero;

    assign sym = shreg[CODE_W-1 -: SYM_W];

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ST_FETCH: begin
                if (rem != '0 && is_mark(sym)) begin
                    tmr_load  = 1'b1;
                    tmr_value = (sym == MORSE_DOT) ? DOT_LOAD : LINE_LOAD;
                end
            end
            ST_MARK: begin
                if (tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_value = GAP_LOAD;
                end
            end
            default: ;
        endcase
    end

    morse_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clock  (clock),
        .resetn (resetn),
        .load   (tmr_load),
        .value  (tmr_value),
        .zero   (tmr_zero)
    );

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            rem        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            morse_out  <= 1'b0;
            cur_symbol <= MORSE_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg <= code;
                        rem   <= REM_INIT;
                        busy  <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (rem == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        shreg <= shreg << SYM_W;
                        rem   <= rem - REM_W'(1);
                        if (is_mark(sym)) begin
                            morse_out  <= 1'b1;
                            cur_symbol <= sym;
                            state      <= ST_MARK;
                        end
                    end
                end
                ST_MARK: begin
                    if (tmr_zero) begin
                        morse_out <= 1'b0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        cur_symbol <= MORSE_NONE;
                        state      <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    morse_out  <= 1'b0;
                    cur_symbol <= MORSE_NONE;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
- Transmit-side counterpart of the morse_decoder input path: takes a 10-bit Morse code word (five 2-bit symbols, MSB symbol first) and plays it out as a timed on/off signal on morse_out.
- Used to play player1's code back on an LED or buzzer, or to drive a decoder in loopback.
- Symbol encoding matches the game datapath:
  - 00 = none (skipped)
  - 01 = dot
  - 11 = line
  - 10 = invalid, treated as none

Parameters:
- UNIT_CYCLES, 12500000, clock cycles per Morse time unit (0.25 s at 50 MHz); must be >= 2.
- DOT_UNITS, 1, mark length of a dot, in units.
- LINE_UNITS, 3, mark length of a line, in units.
- GAP_UNITS, 1, low gap after each emitted mark, in units.

Ports:
- clock  input  1  system clock, all state changes on the rising edge.
- resetn  input  1  reset; asynchronous, active-high (1 = reset asserted), as named in the codebase.
- start  input  1  request playback of code; sampled only in IDLE.
- code  input  10  code word; latched on the accepting start edge.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at end of playback.
- morse_out  output  1  registered Morse waveform, 1 = mark.
- cur_symbol  output  2  symbol currently sounding (01/11) in MARK and GAP, else 00.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - morse_out=0, done=0, busy=0, cur_symbol=00.
  - Shift register and counters are cleared.
- States: IDLE, FETCH, MARK, GAP, DONE.
- IDLE:
  - start=1 latches code into shreg[9:0], sets rem=5 and goes to FETCH.
  - Otherwise the block stays in IDLE.
- FETCH, rem>0:
  - Inspects shreg[9:8], then shreg <= shreg<<2 and rem <= rem-1.
  - Dot (01): MARK, morse_out<=1, cnt <= DOT_UNITS*UNIT_CYCLES-1.
  - Line (11): MARK, morse_out<=1, cnt <= LINE_UNITS*UNIT_CYCLES-1.
  - None (00 or 10): stays in FETCH. Each skipped symbol costs exactly 1 cycle, with morse_out low.
- FETCH, rem==0: goes to DONE.
- MARK:
  - cnt decrements each cycle.
  - At cnt==0: GAP, morse_out<=0, cnt <= GAP_UNITS*UNIT_CYCLES-2.
  - A dot is high exactly DOT_UNITS*UNIT_CYCLES cycles; a line is high exactly LINE_UNITS*UNIT_CYCLES cycles.
- GAP:
  - cnt decrements each cycle.
  - At cnt==0: FETCH.
  - Low time between consecutive marks is exactly GAP_UNITS*UNIT_CYCLES (GAP plus one FETCH), plus 1 cycle per skipped symbol.
  - The trailing gap after the last mark is always played.
- DONE: done=1 for exactly one cycle, then IDLE.
- Handshake and edge cases:
  - start while busy: ignored, no queuing.
  - code changes while busy: no effect, since the word is latched.
  - start held high: a new playback is accepted on the first IDLE cycle after DONE.
  - code=0: no marks; done still pulses.
- Counter width: $clog2(LINE_UNITS*UNIT_CYCLES). The larger of the DOT/LINE products sizes the counter; all products are computed at elaboration.
- Total playback cycles from the accepting edge to DONE: 1 + sum over emitted marks of (mark + GAP_UNITS*UNIT_CYCLES) + (number of skipped symbols) + 1.
- Reset mid-playback: waveform aborts at once and done does not pulse.

Decomposition:
- Shared package morse_pkg:
  - Symbol constants MORSE_NONE=2'b00, MORSE_DOT=2'b01, MORSE_LINE=2'b11.
  - State encoding localparams.
  - CODE_W=10 and SYM_W=2.
  - Used by this block and by the decoder/player side.
- One natural sub-module: morse_timer, a loadable down-counter with zero flag, width as above. Everything else stays in morse_encoder.

Test Plan:
Benches use UNIT_CYCLES=4 and other defaults. Edge 0 is the start-accept edge.

- Dot then line, code=10'b01_11_00_00_00:
  - morse_out high edges 1–5 (4 cycles), low 5–9, high 9–21 (12 cycles), low thereafter.
  - done=1 after edge 28 for one cycle; busy falls at edge 29.
- code=10'b0000000000:
  - morse_out never high.
  - done pulses after edge 6; busy high edges 0–7.
- code=10'b11_00_01_00_11:
  - Marks 12, 4, 12 cycles.
  - Low intervals: 5 cycles (one skip), then 5 cycles (one skip).
  - done pulses after the fifth symbol's trailing gap.
- Invalid symbols, code=10'b10_10_01_10_10: behaves as none/dot/none, giving one 4-cycle mark starting at edge 3.
- Start and code changes while busy:
  - Pulse start with code=10'b11_11_11_11_11 at edge 10 of the first scenario: ignored, first waveform unchanged.
  - Holding start through DONE: replay begins on the IDLE cycle.
- Mid-playback reset: assert resetn during a line mark.
  - morse_out, busy and cur_symbol go 0 before the next edge; no done pulse.
  - A later start plays normally.
